// File: rtl/sum3_pkg.sv
// Shared definitions for the sum_3 sequencer: default widths, FSM state
// encoding and a saturating fill-counter helper.
package sum3_pkg;

    localparam int DW_DEF     = 8;
    localparam int WIN_DEF    = 3;
    localparam int MA_LAT_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    // Increment a 2-bit fill count, stopping at lim.
    function automatic logic [1:0] sat_inc(input logic [1:0] v, input logic [1:0] lim);
        return (v >= lim) ? lim : v + 2'd1;
    endfunction

endpackage

// File: rtl/sum3_lat_timer.sv
// Datapath latency timer: loaded when a sample is issued, pulses o_done on
// the last of MA_LAT wait cycles so the controller captures ma_out then.
module sum3_lat_timer
    import sum3_pkg::*;
#(
    parameter int MA_LAT = MA_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_done
);

    localparam int CW = $clog2(MA_LAT + 1);

    logic [CW-1:0] r_cnt;

    // Down-counter: load MA_LAT on issue, count to zero, then idle at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(MA_LAT);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_done = (r_cnt == CW'(1));

endmodule

// File: rtl/sum_3_seq_ctrl.sv
// Sequencer for the 3-tap signed moving-average datapath (sum_3).
// Accepts one sample at a time, pulses ma_en, waits out the datapath latency
// and presents the registered average on a valid/ready stream. Results from a
// partially filled window are dropped unless SUM3_WARMUP_PASS_EN is defined,
// in which case they are emitted and flagged on m_warm.
module sum_3_seq_ctrl
    import sum3_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int WIN    = WIN_DEF,
    parameter int MA_LAT = MA_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          flush,
    output logic          ma_en,
    output logic          ma_clr,
    output logic [DW-1:0] ma_in,
    input  logic [DW-1:0] ma_out,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [1:0]    fill_cnt,
`ifdef SUM3_WARMUP_PASS_EN
    output logic          m_warm,
`endif
    output logic          busy
);

    localparam logic [1:0] WIN_L = 2'(WIN);

    state_t        r_state;
    state_t        w_next;
    logic          r_flush_pend;
    logic [DW-1:0] r_ma_in;
    logic [DW-1:0] r_m_data;
    logic [1:0]    r_fill;
    logic          w_accept;
    logic          w_done;
    logic          w_keep;

    sum3_lat_timer #(.MA_LAT(MA_LAT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (r_state == ST_ISSUE),
        .o_done (w_done)
    );

`ifdef SUM3_WARMUP_PASS_EN
    logic r_warm;
    assign w_keep = 1'b1;
    assign m_warm = r_warm;

    // Flag results that came from a window not yet full since the last clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm <= 1'b0;
        end else if (r_state == ST_WAIT && w_done) begin
            r_warm <= (r_fill != WIN_L);
        end
    end
`else
    assign w_keep = (r_fill == WIN_L);
`endif

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake/strobe outputs.
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next   = r_state;
        s_ready  = 1'b0;
        ma_en    = 1'b0;
        ma_clr   = rst;
        m_valid  = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                s_ready = !flush && !r_flush_pend && !rst;
                if (flush || r_flush_pend) begin
                    w_next = ST_CLEAR;
                end else if (s_valid && s_ready) begin
                    w_accept = 1'b1;
                    w_next   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ma_en  = 1'b1;
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_done) begin
                    w_next = w_keep ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    w_next = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                ma_clr = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Sample latch, fill count, result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ma_in  <= '0;
            r_m_data <= '0;
            r_fill   <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_accept) r_ma_in <= s_data;
                ST_ISSUE: r_fill <= sat_inc(r_fill, WIN_L);
                ST_WAIT:  if (w_done && w_keep) r_m_data <= ma_out;
                ST_CLEAR: r_fill <= 2'd0;
                default:  ;
            endcase
        end
    end

    // Remember a flush that arrives mid-sample; CLEAR consumes it from IDLE.
    // A flush during CLEAR is absorbed since the window is being cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_pend <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_flush_pend <= 1'b0;
        end else if (flush && r_state != ST_IDLE) begin
            r_flush_pend <= 1'b1;
        end
    end

    assign ma_in    = r_ma_in;
    assign m_data   = r_m_data;
    assign fill_cnt = r_fill;
    assign busy     = (r_state != ST_IDLE) || r_flush_pend;

endmodule
